// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Minimum number of bits needed to encode the values 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted req searching upward
// from last+1, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] idx_c;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    idx_c = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx_c = IDX_W'((int'(last) + off) % NUM_REQ);
      if (req[idx_c]) begin
        valid = 1'b1;
        idx   = idx_c;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts and stall on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic                  wr_any;
  logic                  req_owner;
  logic [DATA_WIDTH-1:0] data_mux;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // gnt_q is one-hot on the owner, so masking with it selects the owner's lane.
  assign ack        = gnt_q & req & {NUM_REQ{~fifo_full}};
  assign wr_any     = |ack;
  assign req_owner  = |(gnt_q & req);
  assign gnt        = gnt_q;
  assign fifo_wr_en = wr_any;

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) data_mux = data_mux | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_data_in = data_mux;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid && !fifo_full) begin
          owner_d = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wr_any) cnt_d = cnt_q + 1'b1;
        // A full FIFO alone never ends the burst; the owner keeps its slot.
        if ((wr_any && cnt_q == CNT_LAST) || !req_owner) begin
          gnt_d   = '0;
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with a behavioural depth-8 FIFO and
// queue-backed producers that advance only on their own ack.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    ack;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pq[NR][$];
  logic [7:0] fifo_q[$];
  logic [7:0] wr_log[$];
  int         grant_log[$];
  int         grant_cyc[$];
  int         burst_acks[$];
  int         pop_pend = 0;
  bit         auto_pop = 1'b0;
  int         viol = 0;
  int         cyc = 0;

  logic [NR-1:0] ack_s, prev_gnt;
  logic          wr_s;
  logic [7:0]    data_s;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
  );

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req[i] = (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    fifo_full = (fifo_q.size() >= DEPTH);
  endtask

  // Observation: sample mid-cycle, log grants/acks and protocol violations.
  always @(negedge clk) begin
    ack_s  = ack;
    wr_s   = fifo_wr_en;
    data_s = fifo_data_in;
    if (!rst) begin
      if (gnt != 0 && prev_gnt == 0) begin
        grant_log.push_back(onehot_idx(gnt));
        grant_cyc.push_back(cyc);
        burst_acks.push_back(0);
      end
      if (ack != 0 && burst_acks.size() > 0) burst_acks[burst_acks.size()-1]++;
      if ((ack & ~gnt) != 0) viol++;
      if (fifo_wr_en !== (|ack)) viol++;
      if (fifo_wr_en && fifo_full) viol++;
      if ($countones(gnt) > 1) viol++;
    end
    prev_gnt = gnt;
  end

  // FIFO and producer model: everything moves on the rising edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (pop_pend > 0 && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pop_pend--;
      end else if (auto_pop && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
      end
      if (wr_s) begin
        fifo_q.push_back(data_s);
        wr_log.push_back(data_s);
      end
      for (int i = 0; i < NR; i++) begin
        if (ack_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      end
    end
    #1 refresh();
  end

  task automatic clear_model();
    auto_pop = 1'b0;
    pop_pend = 0;
    for (int i = 0; i < NR; i++) pq[i].delete();
    fifo_q.delete();
    wr_log.delete();
    grant_log.delete();
    grant_cyc.delete();
    burst_acks.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
          pq[3].size() == 0 && gnt == 0 && req == 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", fifo_data_in); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_no_req_gnt: got %b want 0000", gnt); end
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    #1;
    for (int j = 1; j <= 6; j++) pq[2].push_back(8'(j));
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_latency_early: got %b want 0000", gnt); end
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_latency_gnt: got %b want 0100", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL single_first_wr: got %b want 1", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 8'h01) begin n_bad++; $display("FAIL single_first_data: got %h want 01", fifo_data_in); end
    wait_done(40, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got %b want 0", to); end
    n_cmp++; if (grant_log.size() !== 2) begin n_bad++; $display("FAIL single_grants: got %0d want 2", grant_log.size()); end
    if (grant_log.size() == 2) begin
      n_cmp++; if (grant_log[0] !== 2 || grant_log[1] !== 2) begin n_bad++; $display("FAIL single_owner: got %0d,%0d want 2,2", grant_log[0], grant_log[1]); end
      n_cmp++; if (burst_acks[0] !== 4 || burst_acks[1] !== 2) begin n_bad++; $display("FAIL single_burst_len: got %0d,%0d want 4,2", burst_acks[0], burst_acks[1]); end
      n_cmp++; if (grant_cyc[1] - grant_cyc[0] !== 5) begin n_bad++; $display("FAIL single_gap: got %0d want 5", grant_cyc[1] - grant_cyc[0]); end
    end
    n_cmp++; if (fifo_q.size() !== 6) begin n_bad++; $display("FAIL single_fifo_count: got %0d want 6", fifo_q.size()); end
    for (int k = 0; k < 6 && k < fifo_q.size(); k++) begin
      n_cmp++; if (fifo_q[k] !== 8'(k + 1)) begin n_bad++; $display("FAIL single_fifo_word%0d: got %h want %h", k, fifo_q[k], 8'(k + 1)); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL single_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    #1;
    auto_pop = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 8; j++) pq[i].push_back(8'(16 * i + j));
    for (int c = 0; c < 60 && grant_log.size() < 5; c++) @(negedge clk);
    n_cmp++; if (grant_log.size() < 5) begin n_bad++; $display("FAIL rr_grants: got %0d want >=5", grant_log.size()); end
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++; if (grant_log[k] !== exp_order[k]) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, grant_log[k], exp_order[k]); end
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (burst_acks[k] !== MB) begin n_bad++; $display("FAIL rr_burst%0d: got %0d want %0d", k, burst_acks[k], MB); end
        n_cmp++; if (grant_cyc[k+1] - grant_cyc[k] !== MB + 1) begin n_bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, grant_cyc[k+1] - grant_cyc[k], MB + 1); end
      end
    end
    n_cmp++; if (wr_log.size() < 16) begin n_bad++; $display("FAIL rr_writes: got %0d want >=16", wr_log.size()); end
    for (int k = 0; k < 16 && k < wr_log.size(); k++) begin
      n_cmp++; if (wr_log[k] !== 8'(16 * (k / 4) + (k % 4))) begin n_bad++; $display("FAIL rr_word%0d: got %h want %h", k, wr_log[k], 8'(16 * (k / 4) + (k % 4))); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rr_protocol: got %0d violations want 0", viol); end
    auto_pop = 1'b0;
  endtask

  task automatic test_full_stall();
    bit to;
    logic [7:0] exp_f[8] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'h31, 8'h32, 8'h33};
    do_reset();
    #1;
    for (int j = 0; j < 7; j++) fifo_q.push_back(8'hA0 + 8'(j));
    pq[1].push_back(8'h31); pq[1].push_back(8'h32); pq[1].push_back(8'h33);
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL stall_first_ack: got %b want 0010", ack); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL stall_gnt_held%0d: got %b want 0010", c, gnt); end
      n_cmp++; if (ack !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL stall_no_write%0d: got ack %b wr %b want 0000 0", c, ack, fifo_wr_en); end
    end
    pop_pend = 2;
    wait_done(40, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL stall_timeout: got %b want 0", to); end
    n_cmp++; if (grant_log.size() !== 1 || burst_acks.size() !== 1) begin n_bad++; $display("FAIL stall_grants: got %0d want 1", grant_log.size()); end
    else begin
      n_cmp++; if (burst_acks[0] !== 3) begin n_bad++; $display("FAIL stall_acks: got %0d want 3", burst_acks[0]); end
    end
    n_cmp++; if (fifo_q.size() !== 8) begin n_bad++; $display("FAIL stall_fifo_count: got %0d want 8", fifo_q.size()); end
    for (int k = 0; k < 8 && k < fifo_q.size(); k++) begin
      n_cmp++; if (fifo_q[k] !== exp_f[k]) begin n_bad++; $display("FAIL stall_word%0d: got %h want %h", k, fifo_q[k], exp_f[k]); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL stall_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_early_release();
    bit to;
    logic [7:0] exp_w[4] = '{8'h3A, 8'h3B, 8'h0A, 8'h0B};
    do_reset();
    #1;
    pq[3].push_back(8'h3A); pq[3].push_back(8'h3B);
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL early_gnt3: got %b want 1000", gnt); end
    #1;
    pq[0].push_back(8'h0A); pq[0].push_back(8'h0B);
    wait_done(40, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL early_timeout: got %b want 0", to); end
    #1;
    pq[1].push_back(8'h1C); pq[3].push_back(8'h3C);
    wait_done(40, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL early_timeout2: got %b want 0", to); end
    n_cmp++; if (grant_log.size() !== 4) begin n_bad++; $display("FAIL early_grants: got %0d want 4", grant_log.size()); end
    if (grant_log.size() == 4) begin
      n_cmp++; if (grant_log[0] !== 3 || grant_log[1] !== 0) begin n_bad++; $display("FAIL early_order: got %0d,%0d want 3,0", grant_log[0], grant_log[1]); end
      n_cmp++; if (burst_acks[0] !== 2) begin n_bad++; $display("FAIL early_acks: got %0d want 2", burst_acks[0]); end
      n_cmp++; if (grant_cyc[1] - grant_cyc[0] !== 4) begin n_bad++; $display("FAIL early_gap: got %0d want 4", grant_cyc[1] - grant_cyc[0]); end
      n_cmp++; if (grant_log[2] !== 1 || grant_log[3] !== 3) begin n_bad++; $display("FAIL early_pointer: got %0d,%0d want 1,3", grant_log[2], grant_log[3]); end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (k >= wr_log.size() || wr_log[k] !== exp_w[k]) begin n_bad++; $display("FAIL early_word%0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : 8'hxx, exp_w[k]); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL early_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    logic [7:0] exp_w[4] = '{8'h01, 8'h02, 8'h11, 8'h12};
    do_reset();
    #1;
    for (int j = 1; j <= 6; j++) pq[2].push_back(8'h20 + 8'(j));
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      #1;
      if (ack[2]) n++;
    end
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL rstmid_reach_word3: got %0d want 3", n); end
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rstmid_gnt: got %b want 0000", gnt); end
    n_cmp++; if (fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin n_bad++; $display("FAIL rstmid_wr: got wr %b ack %b want 0 0000", fifo_wr_en, ack); end
    n_cmp++; if (fifo_data_in !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", fifo_data_in); end
    clear_model();
    pq[1].push_back(8'h11); pq[1].push_back(8'h12);
    pq[0].push_back(8'h01); pq[0].push_back(8'h02);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done(40, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout: got %b want 0", to); end
    n_cmp++; if (grant_log.size() !== 2) begin n_bad++; $display("FAIL rstmid_grants: got %0d want 2", grant_log.size()); end
    else begin
      n_cmp++; if (grant_log[0] !== 0 || grant_log[1] !== 1) begin n_bad++; $display("FAIL rstmid_order: got %0d,%0d want 0,1", grant_log[0], grant_log[1]); end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (k >= wr_log.size() || wr_log[k] !== exp_w[k]) begin n_bad++; $display("FAIL rstmid_word%0d: got %h want %h", k, (k < wr_log.size()) ? wr_log[k] : 8'hxx, exp_w[k]); end
    end
  endtask

  task automatic test_idle_full();
    do_reset();
    #1;
    for (int j = 0; j < DEPTH; j++) fifo_q.push_back(8'hC0 + 8'(j));
    pq[0].push_back(8'h05); pq[3].push_back(8'h35);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL idlefull_cycle%0d: got gnt %b wr %b want 0000 0", c, gnt, fifo_wr_en); end
    end
    n_cmp++; if (wr_log.size() !== 0) begin n_bad++; $display("FAIL idlefull_writes: got %0d want 0", wr_log.size()); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL idlefull_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_full_stall();
    test_early_release();
    test_reset_mid();
    test_idle_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
